// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller with IF/ID pipeline register.
// It keeps at most one instruction-memory request outstanding. A word that
// returns while ID is stalled is parked in a one-entry hold buffer. Taken
// branches and jumps from ID redirect the PC after the delay slot has issued.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  // hazard / stall unit
  input  logic        stall_pc,
  input  logic        stall_if_id,
  input  logic        flush_if_id,
  // redirect from ID
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  // instruction memory
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  // IF/ID register
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // ready to issue the next fetch
    S_WAIT = 2'd1,  // request accepted, waiting for data
    S_HOLD = 2'd2   // data returned while ID was stalled; parked in buffer
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_inst_q, if_id_inst_d;

  // Instruction delivered towards IF/ID in this cycle (before flush/stall).
  logic        deliver;
  logic [31:0] deliver_pc;
  logic [31:0] deliver_inst;

  // Redirect targets are word addresses; the two low bits carry no meaning.
  logic [31:0] redirect_tgt;
  assign redirect_tgt = redirect_target & ~32'd3;

  // Fetch request is a pure function of state, pc and stall_pc; no request
  // while reset is asserted.
  assign inst_req  = (state_q == S_REQ) && !stall_pc && !rst;
  assign inst_addr = pc_q;

  assign if_id_valid = if_id_valid_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_inst  = if_id_inst_q;

  // Next-state, PC sequencing, hold buffer and IF/ID load selection.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    req_pc_d      = req_pc_q;
    hold_inst_d   = hold_inst_q;
    hold_pc_d     = hold_pc_q;
    deliver       = 1'b0;
    deliver_pc    = 32'd0;
    deliver_inst  = 32'd0;
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_inst_d  = if_id_inst_q;

    unique case (state_q)
      S_REQ: begin
        // A stale inst_data_ok seen here is deliberately ignored.
        if (inst_req) begin
          req_pc_d = pc_q;
          if (pend_valid_q) begin
            // The delay slot is issuing now; the deferred target follows it.
            pc_d         = pend_target_q;
            pend_valid_d = 1'b0;
          end else begin
            pc_d = pc_q + 32'd4;
          end
          state_d = S_WAIT;
        end
        if (redirect_valid) begin
          if (inst_req) begin
            // The request going out this cycle is the delay slot.
            pc_d = redirect_tgt;
          end else begin
            // Delay slot has not issued yet: remember the target for later.
            pend_valid_d  = 1'b1;
            pend_target_d = redirect_tgt;
          end
        end
      end

      S_WAIT: begin
        // Delay slot is already in flight, the target is the next fetch.
        if (redirect_valid) begin
          pc_d = redirect_tgt;
        end
        if (inst_data_ok) begin
          if (flush_if_id || !stall_if_id) begin
            // A flush in the same cycle turns this into a bubble below.
            deliver      = 1'b1;
            deliver_pc   = req_pc_q;
            deliver_inst = inst_rdata;
            state_d      = S_REQ;
          end else begin
            hold_inst_d = inst_rdata;
            hold_pc_d   = req_pc_q;
            state_d     = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          pc_d = redirect_tgt;
        end
        // Release the parked word when ID frees up; a flush discards it.
        if (flush_if_id || !stall_if_id) begin
          deliver      = 1'b1;
          deliver_pc   = hold_pc_q;
          deliver_inst = hold_inst_q;
          state_d      = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase

    // IF/ID priority: flush, then stall, then new instruction, then bubble.
    if (flush_if_id) begin
      if_id_valid_d = 1'b0;
      if_id_pc_d    = 32'd0;
      if_id_inst_d  = 32'd0;
    end else if (stall_if_id) begin
      if_id_valid_d = if_id_valid_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_inst_d  = if_id_inst_q;
    end else if (deliver) begin
      if_id_valid_d = 1'b1;
      if_id_pc_d    = deliver_pc;
      if_id_inst_d  = deliver_inst;
    end else begin
      if_id_valid_d = 1'b0;
      if_id_pc_d    = 32'd0;
      if_id_inst_d  = 32'd0;
    end
  end

  // State register; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'd0;
      req_pc_q      <= 32'd0;
      hold_inst_q   <= 32'd0;
      hold_pc_q     <= 32'd0;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= 32'd0;
      if_id_inst_q  <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      req_pc_q      <= req_pc_d;
      hold_inst_q   <= hold_inst_d;
      hold_pc_q     <= hold_pc_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_inst_q  <= if_id_inst_d;
    end
  end

  // A deferred redirect can only exist while waiting to issue the delay slot.
  a_pend_only_in_req: assert property (@(posedge clk) disable iff (rst)
    pend_valid_q |-> (state_q == S_REQ));

  // A bubble in IF/ID always carries zero pc and instruction.
  a_bubble_is_zero: assert property (@(posedge clk) disable iff (rst)
    !if_id_valid_q |-> (if_id_pc_q == 32'd0 && if_id_inst_q == 32'd0));

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Randomised scoreboard bench for if_fetch_ctrl. The stimulus process drives
// inputs each cycle, advances a fetch-stream reference model and queues the
// expected request address and IF/ID contents; independent monitors compare.
module tb_if_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_pc = 1'b0;
  logic        stall_if_id = 1'b0;
  logic        flush_if_id = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = 32'd0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;

  always #5 clk = ~clk;

  if_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_pc       (stall_pc),
    .stall_if_id    (stall_if_id),
    .flush_if_id    (flush_if_id),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_inst     (if_id_inst)
  );

  typedef struct {
    int          cyc;
    logic [31:0] addr;
  } req_exp_t;

  typedef struct {
    int          cyc;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } ifid_exp_t;

  req_exp_t  req_q[$];
  ifid_exp_t ifid_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Reference model: the fetch stream as "next address to fetch", an
  // optional deferred target, one outstanding memory word and one parked word.
  logic [31:0] m_next, m_pend_t, m_mem_addr, m_held_pc, m_held_inst;
  logic [31:0] m_pc, m_inst;
  logic        m_pend_v, m_mem_busy, m_held_v, m_valid;

  task automatic model_edge();
    logic        busy, issue, dok;
    logic [31:0] tgt;
    if (rst) begin
      m_next     = RESET_PC;
      m_pend_v   = 1'b0;
      m_mem_busy = 1'b0;
      m_held_v   = 1'b0;
      m_valid    = 1'b0;
      m_pc       = 32'd0;
      m_inst     = 32'd0;
    end else begin
      busy  = m_mem_busy || m_held_v;
      issue = !busy && !stall_pc;
      dok   = inst_data_ok && m_mem_busy;
      if (dok) m_mem_busy = 1'b0;
      if (flush_if_id) begin
        m_valid  = 1'b0;
        m_pc     = 32'd0;
        m_inst   = 32'd0;
        m_held_v = 1'b0;
      end else if (stall_if_id) begin
        if (dok) begin
          m_held_v    = 1'b1;
          m_held_pc   = m_mem_addr;
          m_held_inst = inst_rdata;
        end
      end else if (dok) begin
        m_valid = 1'b1;
        m_pc    = m_mem_addr;
        m_inst  = inst_rdata;
      end else if (m_held_v) begin
        m_valid  = 1'b1;
        m_pc     = m_held_pc;
        m_inst   = m_held_inst;
        m_held_v = 1'b0;
      end else begin
        m_valid = 1'b0;
        m_pc    = 32'd0;
        m_inst  = 32'd0;
      end
      if (issue) begin
        req_q.push_back('{cyc, m_next});
        m_mem_addr = m_next;
        m_mem_busy = 1'b1;
        if (m_pend_v) begin
          m_next   = m_pend_t;
          m_pend_v = 1'b0;
        end else begin
          m_next = m_next + 32'd4;
        end
      end
      if (redirect_valid) begin
        tgt = {redirect_target[31:2], 2'b00};
        // Delay slot already issued (now or earlier): target is next fetch.
        if (issue || busy) begin
          m_next = tgt;
        end else begin
          m_pend_v = 1'b1;
          m_pend_t = tgt;
        end
      end
    end
    ifid_q.push_back('{cyc, m_valid, m_pc, m_inst});
  endtask

  // One clock of stimulus; percentages select how often each input fires.
  task automatic step(input bit r, input bit stale, input int p_spc, input int p_sif,
                      input int p_fl, input int p_rd, input int p_dok);
    @(negedge clk);
    cyc++;
    rst            = r;
    stall_pc       = ($urandom_range(99) < p_spc);
    stall_if_id    = ($urandom_range(99) < p_sif);
    flush_if_id    = ($urandom_range(99) < p_fl);
    redirect_valid = ($urandom_range(99) < p_rd);
    if ($urandom_range(9) == 0)
      redirect_target = 32'hFFFF_FFF8 | ($urandom & 32'd3);
    else
      redirect_target = $urandom;
    inst_rdata = $urandom;
    if (m_mem_busy)
      inst_data_ok = ($urandom_range(99) < p_dok);
    else if (!m_held_v)
      inst_data_ok = stale || ($urandom_range(99) < 5);  // stray return, must be ignored
    else
      inst_data_ok = 1'b0;
    model_edge();
  endtask

  // Request monitor: combinational request checked mid-cycle.
  req_exp_t mon_r;
  always @(negedge clk) begin
    #1;
    if (inst_req) begin
      vectors++;
      if (req_q.size() != 0 && req_q[0].cyc == cyc) begin
        mon_r = req_q.pop_front();
        $display("req cycle %0d addr %h", cyc, inst_addr);
        if (inst_addr !== mon_r.addr) begin
          miscompares++;
          $display("FAIL inst_addr cycle %0d: got %h expected %h", cyc, inst_addr, mon_r.addr);
        end
      end else begin
        miscompares++;
        $display("FAIL req_unexpected cycle %0d: got inst_req=1 addr %h expected inst_req=0",
                 cyc, inst_addr);
      end
    end else if (req_q.size() != 0 && req_q[0].cyc == cyc) begin
      mon_r = req_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL req_missing cycle %0d: got inst_req=0 expected request at %h",
               cyc, mon_r.addr);
    end
  end

  // IF/ID monitor: registered outputs checked just after each edge.
  ifid_exp_t mon_i;
  always @(posedge clk) begin
    #1;
    if (ifid_q.size() != 0) begin
      mon_i = ifid_q.pop_front();
      vectors++;
      if (if_id_valid !== mon_i.valid || if_id_pc !== mon_i.pc || if_id_inst !== mon_i.inst) begin
        miscompares++;
        $display("FAIL if_id cycle %0d: got v=%b pc=%h inst=%h expected v=%b pc=%h inst=%h",
                 mon_i.cyc, if_id_valid, if_id_pc, if_id_inst,
                 mon_i.valid, mon_i.pc, mon_i.inst);
      end
    end
  end

  initial begin
    m_next = RESET_PC; m_pend_t = 0; m_mem_addr = 0; m_held_pc = 0; m_held_inst = 0;
    m_pc = 0; m_inst = 0; m_pend_v = 0; m_mem_busy = 0; m_held_v = 0; m_valid = 0;

    // Reset, then free run with single-cycle memory and a stale return.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 0, 0, 0, 100);
    step(1'b0, 1'b1, 0, 0, 0, 0, 100);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 0, 0, 0, 0, 100);

    // Mixed traffic with occasional mid-operation resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) == 0) begin
        step(1'b1, 1'b0, 25, 25, 10, 12, 50);
        step(1'b0, 1'b1, 25, 25, 10, 12, 50);
      end else begin
        step(1'b0, 1'b0, 25, 25, 10, 12, 50);
      end
    end

    // Heavy PC stalls to exercise deferred redirects.
    for (int i = 0; i < 800; i++) step(1'b0, 1'b0, 60, 15, 5, 20, 70);

    // Heavy ID stalls to exercise the hold buffer.
    for (int i = 0; i < 600; i++) step(1'b0, 1'b0, 10, 60, 8, 10, 80);

    step(1'b0, 1'b0, 100, 0, 0, 0, 0);
    @(negedge clk);
    #3;
    vectors++;
    if (req_q.size() != 0 || ifid_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d req and %0d if_id entries left expected 0 and 0",
               req_q.size(), ifid_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch controller and IF/ID pipeline register for the MIPS core. It consumes the `stall_pc`, `stall_if_id` and `flush_if_id` controls produced by the hazard/stall unit. It also takes branch/jump redirects from ID, honouring the MIPS branch delay slot. It drives a single-outstanding-request instruction-memory interface and presents fetched instructions to ID.

## Interface
- `RESET_PC`, 32'hBFC0_0000, address of the first fetch after reset

- `clk` in 1: system clock, all state updates on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `stall_pc` in 1: hazard unit; blocks issue of a new fetch request.
- `stall_if_id` in 1: hazard unit; IF/ID register holds its contents.
- `flush_if_id` in 1: hazard unit; IF/ID register loads a bubble.
- `redirect_valid` in 1: ID; branch/jump taken, one-cycle pulse.
- `redirect_target` in 32: ID; target address, valid with `redirect_valid`.
- `inst_req` out 1: fetch request; memory accepts it in the same cycle.
- `inst_addr` out 32: fetch address, valid while `inst_req`=1.
- `inst_data_ok` in 1: memory returns data; earliest one cycle after the accepted request.
- `inst_rdata` in 32: instruction word, valid with `inst_data_ok`.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `if_id_pc` out 32: PC of the IF/ID instruction.
- `if_id_inst` out 32: IF/ID instruction word. A bubble is 32'h0.

## Operation
- Registers:
  - `pc`: address of the next request.
  - `pend_valid`/`pend_target`: deferred redirect.
  - `req_pc`: address of the outstanding request.
  - `hold_inst`/`hold_pc`: instruction buffer.
  - IF/ID register.
- FSM states:
  - REQ
    - `inst_req` = !`stall_pc`, `inst_addr` = `pc`.
    - On issue: `req_pc` <= `pc`, `pc` <= next_pc, go to WAIT.
    - next_pc = `pend_target` if `pend_valid` (then clear `pend_valid`), else `pc`+4.
  - WAIT
    - `inst_req`=0.
    - On `inst_data_ok`, if IF/ID may load (`stall_if_id`=0): load {1, `req_pc`, `inst_rdata`}, go to REQ.
    - On `inst_data_ok` with `stall_if_id`=1: capture into the hold buffer, go to HOLD.
  - HOLD
    - `inst_req`=0.
    - When `stall_if_id`=0: load IF/ID from the hold buffer, go to REQ.
- IF/ID update priority: `rst` > `flush_if_id` > `stall_if_id` > load new instruction > load bubble.
  - With no stall and no instruction delivered this cycle, IF/ID loads a bubble (valid=0, pc=0, inst=0).
- `flush_if_id` kills any instruction delivered that cycle (WAIT with `inst_data_ok`, or HOLD release); the FSM still moves to REQ.
  - `flush_if_id` in HOLD discards the buffer and moves to REQ.
  - `flush_if_id` in WAIT without `inst_data_ok` does not cancel the request; its data loads normally later.
- Redirect (delay slot):
  - The delay slot is the first request issued after the branch entered IF/ID.
  - If the delay slot is already issued when `redirect_valid` arrives (state WAIT, HOLD, or REQ issuing this cycle): `pc` <= `redirect_target`. This overrides the +4 of a same-cycle issue.
  - If in REQ blocked by `stall_pc`: `pend_valid` <= 1, `pend_target` <= target. The delay slot (`pc`) issues next; the target issues after it.
  - `redirect_target` must be word-aligned; the low 2 bits are ignored (forced 0).
- `inst_data_ok` seen in REQ (e.g. a stale return after reset) is ignored.

## Timing
- Reset (`rst`=1 at an edge):
  - `pc` = `RESET_PC`, state = REQ, `pend_valid` = 0.
  - `if_id_valid`/`if_id_pc`/`if_id_inst` = 0.
  - Hold buffer cleared.
  - `inst_req` = 0 while `rst` is high.
- Reset mid-operation abandons any outstanding request and takes effect at the next edge.
- First `inst_req` in the first cycle with `rst`=0, `inst_addr`=32'hBFC0_0000.
- Fetch-to-IF/ID latency:
  - Issue at cycle t, `inst_data_ok` at t+k (k≥1), IF/ID valid from t+k+1.
  - Next request at t+k+1.
  - Peak throughput is one instruction per 2 cycles with k=1.
- `pc` arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- `inst_req` and `inst_addr` are combinational from state, `pc` and `stall_pc`. All other outputs are registered.

## Test plan
- Reset then free run with memory k=1:
  - Requests at 0xBFC00000, 0xBFC00004, 0xBFC00008 on cycles 0, 2, 4.
  - `if_id_pc` follows on cycles 2, 4, 6 with valid=1.
- Branch at 0xBFC00000 with target 0xBFC00100, `redirect_valid` while the delay slot is in WAIT:
  - Issue sequence 0xBFC00000, 0xBFC00004, 0xBFC00100.
- Same branch with `stall_pc`=1 for 3 cycles covering the redirect:
  - `pend_valid` is set.
  - Issue sequence still 0xBFC00004, then 0xBFC00100.
- `stall_if_id`=1 when `inst_data_ok` returns 0x24020005:
  - State goes to HOLD and IF/ID is unchanged.
  - After the stall drops, IF/ID = 0x24020005 and the next request follows 1 cycle later.
- `flush_if_id`=1 coincident with `inst_data_ok`:
  - IF/ID valid=0, inst=0; the instruction is dropped.
  - The next request is at `req_pc`+4.
- Assert `rst` during WAIT, then return a stale `inst_data_ok`:
  - The stale return is ignored.
  - IF/ID stays 0.
  - Fetch restarts at 0xBFC00000.
